// File: rtl/m_axil_fsb_adapter.sv
// FSB-to-AXI-lite master bridge: one 80-bit request becomes one AXI-lite read or write, then one 80-bit response.
// Request-to-response is 3 cycles with a zero-wait slave; a single transaction is in flight and requests stall until idle.
`timescale 1ns/1ps
module m_axil_fsb_adapter #(
   parameter int WRITE_ACK     = 1,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     resetn_i,
   input  logic                     adpt_slave_v,
   input  logic [79:0]              adpt_slave_data,
   output logic                     adpt_slave_r,
   output logic                     adpt_master_v,
   output logic [79:0]              adpt_master_data,
   input  logic                     adpt_master_r,
   output logic [31:0]              m_axil_awaddr,
   output logic                     m_axil_awvalid,
   input  logic                     m_axil_awready,
   output logic [31:0]              m_axil_wdata,
   output logic [3:0]               m_axil_wstrb,
   output logic                     m_axil_wvalid,
   input  logic                     m_axil_wready,
   input  logic [1:0]               m_axil_bresp,
   input  logic                     m_axil_bvalid,
   output logic                     m_axil_bready,
   output logic [31:0]              m_axil_araddr,
   output logic                     m_axil_arvalid,
   input  logic                     m_axil_arready,
   input  logic [31:0]              m_axil_rdata,
   input  logic [1:0]               m_axil_rresp,
   input  logic                     m_axil_rvalid,
   output logic                     m_axil_rready,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o
);
   typedef struct packed {
      logic [3:0]  op;
      logic [7:0]  tag;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

   state_t                   state, state_nxt;
   req_t                     req_in;
   logic [7:0]               tag_q;
   logic [3:0]               strb_q;
   logic [31:0]              addr_q;
   logic [31:0]              wdata_q;
   logic [3:0]               rsp_op;
   logic [1:0]               rsp_resp;
   logic [31:0]              rsp_rdata;
   logic                     aw_done;
   logic                     w_done;
   logic                     slave_r;
   logic                     accept;
   logic                     err_inc;
   logic [ERR_CNT_WIDTH-1:0] err_count;

   assign req_in = req_t'(adpt_slave_data);
   assign accept = adpt_slave_v & slave_r;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      m_axil_awvalid = 1'b0;
      m_axil_wvalid  = 1'b0;
      m_axil_bready  = 1'b0;
      m_axil_arvalid = 1'b0;
      m_axil_rready  = 1'b0;
      adpt_master_v  = 1'b0;
      err_inc        = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (req_in.op)
                  4'h1:    state_nxt = WR;
                  4'h2:    state_nxt = RD_ADDR;
                  default: begin
                     state_nxt = RESP;
                     err_inc   = 1'b1;
                  end
               endcase
            end
         end
         WR: begin
            // aw and w retire independently; leave once both have handshaken
            m_axil_awvalid = ~aw_done;
            m_axil_wvalid  = ~w_done;
            if ((aw_done || m_axil_awready) && (w_done || m_axil_wready))
               state_nxt = WR_RESP;
         end
         WR_RESP: begin
            m_axil_bready = 1'b1;
            if (m_axil_bvalid) begin
               err_inc   = (m_axil_bresp != 2'b00);
               state_nxt = (WRITE_ACK == 0 && m_axil_bresp == 2'b00) ? IDLE : RESP;
            end
         end
         RD_ADDR: begin
            m_axil_arvalid = 1'b1;
            if (m_axil_arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            m_axil_rready = 1'b1;
            if (m_axil_rvalid) begin
               err_inc   = (m_axil_rresp != 2'b00);
               state_nxt = RESP;
            end
         end
         RESP: begin
            adpt_master_v = 1'b1;
            if (adpt_master_r) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         tag_q     <= '0;
         strb_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_op    <= '0;
         rsp_resp  <= '0;
         rsp_rdata <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         slave_r   <= 1'b0;
         err_count <= '0;
      end else begin
         slave_r <= (state_nxt == IDLE);
         if (accept) begin
            tag_q     <= req_in.tag;
            strb_q    <= req_in.strb;
            addr_q    <= req_in.addr;
            wdata_q   <= req_in.wdata;
            rsp_resp  <= 2'b00;
            rsp_rdata <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_op    <= (req_in.op == 4'h1) ? 4'h9 : (req_in.op == 4'h2) ? 4'hA : 4'hF;
         end
         if (state == WR && m_axil_awready) aw_done <= 1'b1;
         if (state == WR && m_axil_wready)  w_done  <= 1'b1;
         if (state == WR_RESP && m_axil_bvalid) rsp_resp <= m_axil_bresp;
         if (state == RD_DATA && m_axil_rvalid) begin
            rsp_resp  <= m_axil_rresp;
            rsp_rdata <= m_axil_rdata;
         end
         if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
      end
   end

   assign adpt_slave_r     = slave_r;
   assign adpt_master_data = {rsp_op, tag_q, rsp_resp, 2'b00, addr_q, rsp_rdata};
   assign m_axil_awaddr    = addr_q;
   assign m_axil_araddr    = addr_q;
   assign m_axil_wdata     = wdata_q;
   assign m_axil_wstrb     = strb_q;
   assign err_count_o      = err_count;
endmodule

// File: tb/tb_m_axil_fsb_adapter.sv
// Two bridges (WRITE_ACK=1 with 16-bit error counter, WRITE_ACK=0 with 3-bit counter), each driven by
// directed then random requests against a memory-backed AXI-lite slave, with responses checked by a scoreboard.
`timescale 1ns/1ps
module tb_m_axil_fsb_adapter;
   logic clk;
   int   cyc;
   int   checks;
   int   failures;
   bit   lane_done [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // slave behaviour: address window 0xE0-0xEF answers SLVERR, 0xD0-0xDF answers DECERR
   function automatic logic [1:0] resp_of(input logic [31:0] a);
      case (a[7:4])
         4'hE:    return 2'b10;
         4'hD:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int WA = (g == 0) ? 1 : 0;
      localparam int EW = (g == 0) ? 16 : 3;

      logic          resetn, slv_v, slv_r, mst_v, mst_r;
      logic [79:0]   slv_data, mst_data;
      logic [31:0]   awaddr, wdata, araddr, rdata;
      logic [3:0]    wstrb;
      logic [1:0]    bresp, rresp;
      logic          awvalid, awready, wvalid, wready, bvalid, bready;
      logic          arvalid, arready, rvalid, rready;
      logic [EW-1:0] err;

      m_axil_fsb_adapter #(.WRITE_ACK(WA), .ERR_CNT_WIDTH(EW)) dut (
         .clk_i(clk), .resetn_i(resetn),
         .adpt_slave_v(slv_v), .adpt_slave_data(slv_data), .adpt_slave_r(slv_r),
         .adpt_master_v(mst_v), .adpt_master_data(mst_data), .adpt_master_r(mst_r),
         .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
         .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
         .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
         .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
         .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
         .err_count_o(err)
      );

      logic [79:0] exp_pkt [$];
      int          exp_err [$];
      logic [68:0] axi_q [$];
      logic [31:0] ref_mem [logic [31:0]];
      logic [31:0] slv_mem [logic [31:0]];
      int          ref_err;
      bit          rnd;
      int          d_aw, d_w, d_ar, d_b, d_r, hold, last_resp_edge;

      function automatic int pick(input int d);
         return rnd ? int'($urandom_range(0, 3)) : d;
      endfunction

      task automatic bump(input bit inc);
         if (inc && ref_err < (1 << EW) - 1) ref_err++;
      endtask

      task automatic push(input logic [79:0] p);
         exp_pkt.push_back(p);
         exp_err.push_back(ref_err);
      endtask

      task automatic model(input logic [3:0] op, input logic [7:0] tag, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] d);
         logic [1:0]  r;
         logic [31:0] m;
         r = resp_of(a);
         m = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
         case (op)
            4'h1: begin
               axi_q.push_back({1'b1, a, d, st});
               if (r == 2'b00) ref_mem[a] = merge(m, d, st);
               bump(r != 2'b00);
               if (WA != 0 || r != 2'b00) push({4'h9, tag, r, 2'b00, a, 32'h0});
            end
            4'h2: begin
               axi_q.push_back({1'b0, a, 32'h0, 4'h0});
               bump(r != 2'b00);
               push({4'hA, tag, r, 2'b00, a, (r != 2'b00) ? 32'h0BAD_0BAD : m});
            end
            default: begin
               bump(1'b1);
               push({4'hF, tag, 4'h0, a, 32'h0});
            end
         endcase
      endtask

      task automatic send(input logic [3:0] op, input logic [7:0] tag, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d, output int acc);
         int n;
         @(negedge clk);
         slv_v    = 1'b1;
         slv_data = {op, tag, st, a, d};
         n = 0;
         while (!slv_r && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("L%0d accept_timeout", g), n < 300, 1);
         acc = cyc;
         model(op, tag, st, a, d);
         @(posedge clk);
         #1 slv_v = 1'b0;
      endtask

      task automatic lat(output int n, output int ac, output int wc, output int rc);
         n = 0; ac = 0; wc = 0; rc = 0;
         do begin
            @(negedge clk);
            n++;
            ac += int'(awvalid);
            wc += int'(wvalid);
            rc += int'(arvalid);
         end while (!(mst_v || slv_r) && n < 100);
      endtask

      task automatic drain();
         int n;
         n = 0;
         while ((exp_pkt.size() != 0 || !slv_r) && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("L%0d drain_timeout", g), n < 500, 1);
      endtask

      initial begin : slave
         bit          got_aw, got_w, b_act, got_ar, p_aw, p_w, p_ar;
         int          c_aw, c_w, c_b, c_ar, c_r;
         logic [31:0] a_w, d_wr, a_r, h_aw, h_ar;
         logic [35:0] h_w;
         logic [3:0]  s_w;
         logic [68:0] e;
         got_aw = 0; got_w = 0; b_act = 0; got_ar = 0; p_aw = 0; p_w = 0; p_ar = 0;
         c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
         a_w = '0; d_wr = '0; a_r = '0; s_w = '0; h_aw = '0; h_ar = '0; h_w = '0;
         awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
         forever begin
            @(negedge clk);
            if (!resetn) begin
               got_aw = 0; got_w = 0; b_act = 0; got_ar = 0; p_aw = 0; p_w = 0; p_ar = 0;
               awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
               continue;
            end
            if (p_aw) chk($sformatf("L%0d aw_stable", g), {awvalid, awaddr}, {1'b1, h_aw});
            if (p_w)  chk($sformatf("L%0d w_stable", g), {wvalid, wdata, wstrb}, {1'b1, h_w});
            if (p_ar) chk($sformatf("L%0d ar_stable", g), {arvalid, araddr}, {1'b1, h_ar});
            bvalid = 1'b0;
            if (b_act) begin
               if (c_b > 0) c_b--;
               else begin
                  bvalid = 1'b1;
                  bresp  = resp_of(a_w);
                  if (bready) begin
                     b_act = 0; got_aw = 0; got_w = 0;
                     chk($sformatf("L%0d write_expected", g), axi_q.size() != 0, 1);
                     if (axi_q.size() != 0) begin
                        e = axi_q.pop_front();
                        chk($sformatf("L%0d write_op", g), {1'b1, a_w, d_wr, s_w}, e);
                     end
                     if (resp_of(a_w) == 2'b00)
                        slv_mem[a_w] = merge(slv_mem.exists(a_w) ? slv_mem[a_w] : init_word(a_w), d_wr, s_w);
                  end
               end
            end
            awready = 1'b0;
            if (!got_aw) begin
               if (!awvalid) c_aw = pick(d_aw);
               else if (c_aw > 0) c_aw--;
               else begin awready = 1'b1; got_aw = 1; a_w = awaddr; end
            end
            p_aw = awvalid && !awready && !got_aw;
            h_aw = awaddr;
            wready = 1'b0;
            if (!got_w) begin
               if (!wvalid) c_w = pick(d_w);
               else if (c_w > 0) c_w--;
               else begin wready = 1'b1; got_w = 1; d_wr = wdata; s_w = wstrb; end
            end
            p_w = wvalid && !wready && !got_w;
            h_w = {wdata, wstrb};
            if (got_aw && got_w && !b_act) begin
               b_act = 1;
               c_b   = pick(d_b);
            end
            rvalid = 1'b0;
            if (got_ar) begin
               if (c_r > 0) c_r--;
               else begin
                  rvalid = 1'b1;
                  rresp  = resp_of(a_r);
                  rdata  = (rresp != 2'b00) ? 32'h0BAD_0BAD : (slv_mem.exists(a_r) ? slv_mem[a_r] : init_word(a_r));
                  if (rready) got_ar = 0;
               end
            end
            arready = 1'b0;
            if (!got_ar && !rvalid) begin
               if (!arvalid) c_ar = pick(d_ar);
               else if (c_ar > 0) c_ar--;
               else begin
                  arready = 1'b1; got_ar = 1; a_r = araddr; c_r = pick(d_r);
                  chk($sformatf("L%0d read_expected", g), axi_q.size() != 0, 1);
                  if (axi_q.size() != 0) begin
                     e = axi_q.pop_front();
                     chk($sformatf("L%0d read_op", g), {1'b0, araddr, 32'h0, 4'h0}, e);
                  end
               end
            end
            p_ar = arvalid && !arready && !got_ar;
            h_ar = araddr;
         end
      end

      initial begin : monitor
         bit          pend;
         logic [79:0] held, p;
         int          ee;
         pend = 0; held = '0; mst_r = 1'b0;
         forever begin
            @(negedge clk);
            if (!resetn) begin
               pend  = 0;
               mst_r = 1'b0;
               continue;
            end
            if (pend) chk($sformatf("L%0d rsp_stable", g), {mst_v, mst_data}, {1'b1, held});
            pend = 0;
            if (mst_v) begin
               chk($sformatf("L%0d slave_r_in_resp", g), slv_r, 0);
               if (hold > 0) begin
                  hold--;
                  mst_r = 1'b0;
               end else mst_r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
               if (mst_r) begin
                  chk($sformatf("L%0d rsp_expected", g), exp_pkt.size() != 0, 1);
                  if (exp_pkt.size() != 0) begin
                     p  = exp_pkt.pop_front();
                     ee = exp_err.pop_front();
                     chk($sformatf("L%0d rsp_pkt", g), mst_data, p);
                     chk($sformatf("L%0d err_count", g), err, ee);
                  end
                  last_resp_edge = cyc;
               end else begin
                  pend = 1;
                  held = mst_data;
               end
            end else mst_r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end

      initial begin : stim
         int          acc, acc2, n, ac, wc, rc, x;
         logic [3:0]  op;
         logic [31:0] a;
         rnd = 0; d_aw = 0; d_w = 0; d_ar = 0; d_b = 0; d_r = 0; hold = 0;
         ref_err = 0; last_resp_edge = -1;
         resetn = 1'b0; slv_v = 1'b0; slv_data = '0;
         repeat (3) @(negedge clk);
         chk($sformatf("L%0d reset_ctrl", g), {slv_r, mst_v, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
         chk($sformatf("L%0d reset_regs", g), {awaddr, wdata, err}, 0);
         chk($sformatf("L%0d reset_rsp", g), mst_data, 80'h0);
         resetn = 1'b1;
         @(negedge clk);
         chk($sformatf("L%0d ready_after_reset", g), slv_r, 1);

         send(4'h1, 8'h11, 4'hF, 32'h40, 32'hDEAD_BEEF, acc);
         lat(n, ac, wc, rc);
         chk($sformatf("L%0d wr_latency", g), {n, ac, wc}, {32'd3, 32'd1, 32'd1});
         drain();
         send(4'h2, 8'h5A, 4'h0, 32'h40, 32'h0, acc);
         lat(n, ac, wc, rc);
         chk($sformatf("L%0d rd_latency", g), {n, rc}, {32'd3, 32'd1});
         drain();
         chk($sformatf("L%0d err_after_rd", g), err, 0);

         d_aw = 3;
         send(4'h1, 8'h22, 4'hF, 32'h10, 32'h1234_5678, acc);
         lat(n, ac, wc, rc);
         chk($sformatf("L%0d wr_w_first", g), {n, ac, wc}, {32'd6, 32'd4, 32'd1});
         d_aw = 0;
         drain();

         send(4'h1, 8'h33, 4'hF, 32'hE0, 32'hAAAA_5555, acc);
         drain();
         chk($sformatf("L%0d err_after_slverr", g), err, 1);
         send(4'h1, 8'h34, 4'h3, 32'h20, 32'h0BEE_F00D, acc);
         lat(n, ac, wc, rc);
         chk($sformatf("L%0d ok_wr_latency", g), n, 3);
         drain();

         send(4'h7, 8'h3C, 4'h0, 32'h80, 32'h5555_5555, acc);
         lat(n, ac, wc, rc);
         chk($sformatf("L%0d illegal_no_axi", g), {n, ac, wc, rc}, {32'd1, 32'd0, 32'd0, 32'd0});
         drain();
         chk($sformatf("L%0d err_after_illegal", g), err, 2);

         hold = 10;
         send(4'h2, 8'h44, 4'h0, 32'h20, 32'h0, acc);
         send(4'h2, 8'h45, 4'h0, 32'h10, 32'h0, acc2);
         chk($sformatf("L%0d stall_release", g), acc2, last_resp_edge + 1);
         chk($sformatf("L%0d stall_cycles", g), acc2 - acc, 14);
         drain();

         d_ar = 20;
         send(4'h2, 8'h55, 4'h0, 32'h50, 32'h0, acc);
         n = 0;
         while (!arvalid && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("L%0d arvalid_pending", g), arvalid, 1);
         resetn = 1'b0;
         exp_pkt.delete(); exp_err.delete(); axi_q.delete();
         ref_err = 0;
         @(posedge clk);
         #1;
         chk($sformatf("L%0d midreset_ctrl", g), {slv_r, mst_v, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
         chk($sformatf("L%0d midreset_err", g), err, 0);
         @(negedge clk);
         resetn = 1'b1;
         d_ar = 0;
         @(negedge clk);
         chk($sformatf("L%0d ready_after_midreset", g), slv_r, 1);

         rnd = 1;
         for (int i = 0; i < 70; i++) begin
            x  = int'($urandom_range(0, 19));
            op = (x < 9) ? 4'h1 : (x < 18) ? 4'h2 : (x == 18) ? 4'($urandom_range(3, 15)) : 4'h0;
            a  = 32'($urandom_range(0, 63)) << 2;
            send(op, 8'($urandom), 4'($urandom), a, $urandom, acc);
         end
         drain();
         chk($sformatf("L%0d err_final", g), err, ref_err);
         chk($sformatf("L%0d queues_empty", g), {exp_pkt.size(), axi_q.size()}, 64'h0);
         lane_done[g] = 1'b1;
      end
   end

   initial begin : top
      int n;
      checks = 0;
      failures = 0;
      n = 0;
      while (!(lane_done[0] && lane_done[1]) && n < 60000) begin
         @(negedge clk);
         n++;
      end
      chk("lanes_finished", {lane_done[0], lane_done[1]}, 2'b11);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
